// File: rtl/exec_sequencer.sv
// Execution sequencer: HALT / RUN / STEP / BREAK control of the PC advance enable.
// Define EXEC_BREAKPOINT_EN to enable the breakpoint comparator and the BREAK state.
module exec_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_mode,
    input  logic        step_tick,
    input  logic        stall,
    input  logic [31:0] pc_current,
    input  logic [31:0] bp_addr,
    input  logic        bp_valid,
    output logic        pc_en,
    output logic [1:0]  seq_state,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t state;
    logic   bp_hit;

`ifdef EXEC_BREAKPOINT_EN
    assign bp_hit = bp_valid && (pc_current == bp_addr);
`else
    // Breakpoint ports are kept for drop-in compatibility but have no effect.
    logic unused_bp;
    assign unused_bp = ^{pc_current, bp_addr, bp_valid};
    assign bp_hit    = 1'b0;
`endif

    // Reset forces pc_en low in its own cycle, aborting any RUN or STEP in flight.
    always_comb begin
        pc_en = 1'b0;
        if (!reset) begin
            case (state)
                S_RUN:   pc_en = !stall && !bp_hit;
                S_STEP:  pc_en = !stall;
                default: pc_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_HALT;
            retired <= '0;
        end else begin
            if (pc_en) begin
                retired <= retired + 32'd1;
            end
            case (state)
                S_HALT: begin
                    if (run_mode) begin
                        state <= S_RUN;
                    end else if (step_tick) begin
                        state <= S_STEP;
                    end
                end
                S_RUN: begin
                    if (!run_mode) begin
                        state <= S_HALT;
                    end else if (bp_hit) begin
                        state <= S_BREAK;
                    end
                end
                S_STEP: begin
                    if (!stall) begin
                        state <= S_HALT;
                    end
                end
                S_BREAK: begin
                    if (step_tick) begin
                        state <= S_STEP;
                    end else if (!run_mode) begin
                        state <= S_HALT;
                    end
                end
            endcase
        end
    end

    assign seq_state = state;
    assign halted    = (state == S_HALT) || (state == S_BREAK);

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed vector table, corner sequences, random run.
// Honours EXEC_BREAKPOINT_EN the same way the design does.
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset, run_mode, step_tick, stall, bp_valid;
    logic [31:0] pc_current, bp_addr;
    logic        pc_en, halted;
    logic [1:0]  seq_state;
    logic [31:0] retired;

    always #5 clk = ~clk;

    exec_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run_mode   (run_mode),
        .step_tick  (step_tick),
        .stall      (stall),
        .pc_current (pc_current),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .pc_en      (pc_en),
        .seq_state  (seq_state),
        .halted     (halted),
        .retired    (retired)
    );

`ifdef EXEC_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one flag per active mode, none set means halted.
    bit          m_valid = 1'b0;
    bit          m_run   = 1'b0;
    bit          m_step  = 1'b0;
    bit          m_brk   = 1'b0;
    bit          m_last_en = 1'b0;
    logic [31:0] m_ret   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_bp_hit();
        return BP_EN && bp_valid && (pc_current == bp_addr);
    endfunction

    function automatic bit m_en();
        if (reset) return 1'b0;
        return (m_run && !stall && !m_bp_hit()) || (m_step && !stall);
    endfunction

    function automatic logic [1:0] m_state();
        if (m_brk)  return 2'b11;
        if (m_step) return 2'b10;
        if (m_run)  return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_check();
        if (m_valid) begin
            check("model_pc_en", {31'd0, pc_en}, {31'd0, m_en()});
            check("model_seq_state", {30'd0, seq_state}, {30'd0, m_state()});
            check("model_halted", {31'd0, halted}, {31'd0, !(m_run || m_step)});
            check("model_retired", retired, m_ret);
        end
    endtask

    function automatic void model_update();
        bit en;
        bit hit;
        en  = m_en();
        hit = m_bp_hit();
        m_last_en = en;
        if (reset) begin
            m_run = 1'b0; m_step = 1'b0; m_brk = 1'b0;
            m_ret = '0;
            m_valid = 1'b1;
        end else begin
            if (en) m_ret = m_ret + 32'd1;
            if (m_run) begin
                if (!run_mode) m_run = 1'b0;
                else if (hit) begin m_run = 1'b0; m_brk = 1'b1; end
            end else if (m_step) begin
                if (!stall) m_step = 1'b0;
            end else if (m_brk) begin
                if (step_tick) begin m_brk = 1'b0; m_step = 1'b1; end
                else if (!run_mode) m_brk = 1'b0;
            end else begin
                if (run_mode) m_run = 1'b1;
                else if (step_tick) m_step = 1'b1;
            end
        end
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic apply(input bit rst, input bit rm, input bit st, input bit stl);
        reset = rst; run_mode = rm; step_tick = st; stall = stl;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst, rm, st, stl;
        logic [1:0]  exp_state;
        bit          exp_en;
        logic [31:0] exp_ret;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit rst, bit rm, bit st, bit stl,
                                logic [1:0] es, bit ee, logic [31:0] er);
        vec_t v;
        v.rst = rst; v.rm = rm; v.st = st; v.stl = stl;
        v.exp_state = es; v.exp_en = ee; v.exp_ret = er;
        vt.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        bit rm_r;

        reset = 1'b1; run_mode = 1'b0; step_tick = 1'b0; stall = 1'b0;
        bp_valid = 1'b0; bp_addr = '0; pc_current = '0;
        @(negedge clk);

        apply(1, 0, 0, 0); tick();
        apply(1, 0, 0, 0);
        check("reset_pc_en", {31'd0, pc_en}, 32'd0);
        tick();

        // Single step, stalled step, run/step collision, ignored ticks, reset mid-STEP
        add(0,0,1,0, 2'b00,0,0);
        add(0,0,0,0, 2'b10,1,0);
        add(0,0,0,0, 2'b00,0,1);
        add(0,0,1,1, 2'b00,0,1);
        add(0,0,0,1, 2'b10,0,1);
        add(0,0,0,1, 2'b10,0,1);
        add(0,0,0,1, 2'b10,0,1);
        add(0,0,0,0, 2'b10,1,1);
        add(0,0,0,0, 2'b00,0,2);
        add(0,1,1,0, 2'b00,0,2);
        add(0,1,0,0, 2'b01,1,2);
        add(0,1,1,0, 2'b01,1,3);
        add(0,0,0,0, 2'b01,1,4);
        add(0,0,0,0, 2'b00,0,5);
        add(0,0,0,0, 2'b00,0,5);
        add(0,0,1,1, 2'b00,0,5);
        add(0,0,1,1, 2'b10,0,5);
        add(0,0,0,0, 2'b10,1,5);
        add(0,0,0,0, 2'b00,0,6);
        add(0,0,0,0, 2'b00,0,6);
        add(0,0,1,0, 2'b00,0,6);
        add(1,0,0,0, 2'b10,0,6);
        add(0,0,0,0, 2'b00,0,0);

        foreach (vt[i]) begin
            apply(vt[i].rst, vt[i].rm, vt[i].st, vt[i].stl);
            check($sformatf("vec%0d_state", i), {30'd0, seq_state}, {30'd0, vt[i].exp_state});
            check($sformatf("vec%0d_pc_en", i), {31'd0, pc_en}, {31'd0, vt[i].exp_en});
            check($sformatf("vec%0d_retired", i), retired, vt[i].exp_ret);
            check($sformatf("vec%0d_halted", i), {31'd0, halted},
                  {31'd0, (vt[i].exp_state == 2'b00) || (vt[i].exp_state == 2'b11)});
            tick();
        end

        // Free run for 10 cycles
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, 0, 0);
            if (i == 1) check("run_state", {30'd0, seq_state}, 32'd1);
            pulses += int'(pc_en);
            tick();
        end
        check("run_pulses", pulses, 32'd9);
        apply(0, 0, 0, 0);
        check("run_retired", retired, 32'd9);
        check("run_drop_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        apply(0, 0, 0, 0);
        check("run_drop_state", {30'd0, seq_state}, 32'd0);
        tick();

        // Breakpoint at 0x10 while the PC advances by 2 per retired cycle
        apply(1, 0, 0, 0); tick();
        bp_valid = 1'b1; bp_addr = 32'h10; pc_current = 32'h0;
`ifdef EXEC_BREAKPOINT_EN
        for (int g = 0; g < 40 && !m_brk; g++) begin
            apply(0, 1, 0, 0); tick();
            if (m_last_en) pc_current = pc_current + 32'd2;
        end
        apply(0, 1, 0, 0);
        check("bp_pc", pc_current, 32'h10);
        check("bp_state", {30'd0, seq_state}, 32'd3);
        check("bp_pc_en", {31'd0, pc_en}, 32'd0);
        check("bp_halted", {31'd0, halted}, 32'd1);
        tick();
        apply(0, 1, 1, 0); tick();
        apply(0, 1, 0, 0);
        check("bp_step_state", {30'd0, seq_state}, 32'd2);
        check("bp_step_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        pc_current = pc_current + 32'd2;
        apply(0, 1, 0, 0);
        check("bp_halt_state", {30'd0, seq_state}, 32'd0);
        tick();
        apply(0, 1, 0, 0);
        check("bp_resume_state", {30'd0, seq_state}, 32'd1);
        check("bp_resume_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
`else
        for (int g = 0; g < 14; g++) begin
            apply(0, 1, 0, 0); tick();
            if (m_last_en) pc_current = pc_current + 32'd2;
        end
        apply(0, 1, 0, 0);
        check("nobp_passed", {31'd0, pc_current > 32'h10}, 32'd1);
        check("nobp_state", {30'd0, seq_state}, 32'd1);
        tick();
`endif
        bp_valid = 1'b0;

        // Counter wrap, then reset during RUN
        apply(1, 0, 0, 0); tick();
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        m_ret = 32'hFFFF_FFFF;
        apply(0, 0, 1, 0);
        check("wrap_preload", retired, 32'hFFFF_FFFF);
        tick();
        apply(0, 0, 0, 0); tick();
        apply(0, 0, 0, 0);
        check("wrap_retired", retired, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin apply(0, 1, 0, 0); tick(); end
        apply(1, 1, 0, 0);
        check("rst_run_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        apply(0, 0, 0, 0);
        check("rst_run_state", {30'd0, seq_state}, 32'd0);
        check("rst_run_retired", retired, 32'd0);
        tick();

        // Random stimulus against the model
        rm_r = 1'b0;
        bp_addr = 32'h40;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rm_r = ~rm_r;
            bp_valid   = ($urandom_range(0, 1) == 1);
            pc_current = ($urandom_range(0, 3) == 0) ? 32'h40 : $urandom;
            apply($urandom_range(0, 60) == 0, rm_r,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port run_mode, input, 1 bit: free-run select, from the clock-toggle switch level.
REQ-004 The block SHALL have the port step_tick, input, 1 bit: one-cycle single-step pulse from the button debouncer.
REQ-005 The block SHALL have the port stall, input, 1 bit: datapath busy (multi-cycle ALU op); while 1, no advance is issued.
REQ-006 The block SHALL have the port pc_current, input, 32 bits: current program counter.
REQ-007 The block SHALL have the port bp_addr, input, 32 bits: breakpoint address.
REQ-008 The block SHALL have the port bp_valid, input, 1 bit: breakpoint armed.
REQ-009 The block SHALL have the port pc_en, output, 1 bit: PC advance enable; the PC loads pc_next on clk when 1.
REQ-010 The block SHALL have the port seq_state, output, 2 bits: HALT=00, RUN=01, STEP=10, BREAK=11.
REQ-011 The block SHALL have the port halted, output, 1 bit: 1 when seq_state is HALT or BREAK.
REQ-012 The block SHALL have the port retired, output, 32 bits: count of cycles in which pc_en=1.

Function
REQ-013 bp_hit SHALL be combinational: bp_valid and (pc_current == bp_addr).
REQ-014 pc_en SHALL be combinational: (RUN and not stall and not bp_hit) or (STEP and not stall).
REQ-015 HALT transitions SHALL be: run_mode=1 -> RUN; else step_tick=1 -> STEP; else stay; run_mode wins over simultaneous step_tick.
REQ-016 RUN transitions SHALL be, in priority order:
- run_mode=0 -> HALT, with pc_en still evaluated for that cycle per REQ-014.
- bp_hit=1 -> BREAK, with pc_en=0 that cycle.
- otherwise stay.
REQ-017 STEP SHALL issue exactly one pc_en=1 cycle; it stays in STEP while stall=1 and goes to HALT in the cycle pc_en=1; bp_hit is ignored in STEP.
REQ-018 BREAK transitions SHALL be: step_tick=1 -> STEP (executes the breakpoint instruction); else run_mode=0 -> HALT; else stay.
REQ-019 step_tick in RUN or STEP SHALL be ignored and SHALL NOT be queued.
REQ-020 retired SHALL increment by 1 on every clk edge where pc_en=1, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-021 pc_en SHALL never be 1 for more than one cycle per step_tick while not in RUN.

Reset
REQ-022 On reset=1 at clk, the block SHALL set seq_state to HALT, retired to 0, halted to 1, and pc_en to 0; reset overrides every other input in that cycle.
REQ-023 Reset asserted mid-STEP or mid-RUN SHALL abort the sequence; no pc_en is issued in the reset cycle.

Configuration
REQ-024 With macro EXEC_BREAKPOINT_EN defined, the block SHALL implement bp_hit and the BREAK state as specified.
REQ-025 Without EXEC_BREAKPOINT_EN, bp_hit SHALL be constant 0, BREAK SHALL be unreachable, and bp_addr/bp_valid SHALL remain as ports but be ignored; all other behaviour is unchanged.

Verification
REQ-026 Step after reset: reset 2 cycles, run_mode=0, one step_tick -> pc_en=1 for exactly 1 cycle one cycle later, retired=1, seq_state returns to 00.
REQ-027 Step under stall: in HALT, step_tick with stall=1 for 3 cycles -> seq_state=10 for 4 cycles, single pc_en pulse after stall drops, retired=1.
REQ-028 Free run: run_mode=1 for 10 cycles with stall=0 -> seq_state=01 after 1 cycle, pc_en=1 for 9 consecutive cycles, retired=9.
REQ-029 Breakpoint (EXEC_BREAKPOINT_EN): bp_valid=1, bp_addr=0x10, RUN while pc_current steps 0x0, 0x2, ... -> pc_en=0 when pc_current=0x10, seq_state=11; then step_tick -> one pc_en pulse, seq_state 10 then 00, then 01 while run_mode=1.
REQ-030 Simultaneous inputs: in HALT, run_mode=1 and step_tick=1 in the same cycle -> next seq_state=01, not 10.
REQ-031 Wrap and reset: preload retired to 0xFFFFFFFF, one step -> retired=0; then assert reset during RUN -> seq_state=00, pc_en=0, retired=0 next cycle.
